// File: rtl/ni_injector.sv
`default_nettype none
// ============================================================================
//  Module      : ni_injector
//  Description : Network-interface injection stage feeding a router's local
//                input port. Takes a payload-beat stream from the core,
//                allocates a virtual channel per packet (round-robin over VCs
//                that have credit), builds complete flits and drives them
//                into the router local slot. Per-VC credit counters mirror
//                the router's local-port VC buffer occupancy so the injector
//                never overruns a buffer.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   clock, all state changes on the rising edge
//    reset          in   synchronous, active-low reset
//    in_valid       in   core presents a payload beat
//    in_ready       out  beat accepted when in_valid & in_ready
//    in_payload     in   flit payload (PAYLOAD_W bits)
//    in_last        in   beat is the last of its packet
//    in_dest        in   destination, sampled when leaving IDLE
//    credit_valid   in   router freed one slot
//    credit_vc      in   VC of the freed slot
//    out_data       out  flit to router local port (registered)
//    out_valid      out  out_data valid, one cycle per flit (registered)
//    err_credit_ovf out  sticky: credit returned to a full counter
//    err_truncated  out  sticky: packet exceeded MAX_FLITS
// ----------------------------------------------------------------------------
//  Flit layout (W = FLIT_DATA_WIDTH)
//    [W-1:W-4]       destination
//    [W-5:W-6]       type: 00 head, 01 body, 10 tail, 11 head+tail
//    [W-7 -: VC_BITS] VC id
//    [PAYLOAD_W-1:0] payload
// ============================================================================
module ni_injector #(
    parameter  int NUM_VC          = 4,
    parameter  int BUF_DEPTH       = 4,
    parameter  int MAX_FLITS       = 8,
    parameter  int FLIT_DATA_WIDTH = 32,
    localparam int VC_BITS         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int PAYLOAD_W       = FLIT_DATA_WIDTH - 6 - VC_BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic                       in_last,
    input  logic [3:0]                 in_dest,
    input  logic                       credit_valid,
    input  logic [VC_BITS-1:0]         credit_vc,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    output logic                       err_credit_ovf,
    output logic                       err_truncated
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam int BEAT_W = $clog2(MAX_FLITS + 1);

    localparam logic [CNT_W-1:0]   CREDIT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(MAX_FLITS - 1);
    localparam logic [VC_BITS-1:0] LAST_VC     = VC_BITS'(NUM_VC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALLOC = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] TYPE_HEAD      = 2'b00;
    localparam logic [1:0] TYPE_BODY      = 2'b01;
    localparam logic [1:0] TYPE_TAIL      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [3:0]         dest_lat;
    logic [VC_BITS-1:0] cur_vc;
    logic [VC_BITS-1:0] rr_ptr;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]   credit [NUM_VC];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic               hit;
    logic [VC_BITS-1:0] hit_vc;
    logic [VC_BITS-1:0] cand;
    logic [VC_BITS-1:0] rr_next;
    logic               accept;
    logic               send_fire;
    logic               at_max;
    logic               is_tail;
    logic               trunc_fire;
    logic [1:0]         flit_type;
    logic [NUM_VC-1:0]  ret_vec;
    logic [NUM_VC-1:0]  take_vec;
    logic [NUM_VC-1:0]  ovf_vec;

    // Round-robin search: first VC with credit, scanning upward from rr_ptr
    // and wrapping. Only meaningful while in ALLOC.
    always_comb begin
        hit    = 1'b0;
        hit_vc = '0;
        cand   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            cand = VC_BITS'((int'(rr_ptr) + i) % NUM_VC);
            if (!hit && (credit[cand] != '0)) begin
                hit    = 1'b1;
                hit_vc = cand;
            end
        end
    end

    assign rr_next = (hit_vc == LAST_VC) ? '0 : hit_vc + 1'b1;

    assign accept     = in_valid & in_ready;
    assign send_fire  = accept & (state == ST_SEND);
    assign at_max     = (beat_cnt == LAST_BEAT);
    // A beat that reaches MAX_FLITS without in_last is forced to tail.
    assign is_tail    = in_last | at_max;
    assign trunc_fire = send_fire & at_max & ~in_last;

    always_comb begin
        flit_type = TYPE_BODY;
        if (beat_cnt == '0) begin
            flit_type = is_tail ? TYPE_HEAD_TAIL : TYPE_HEAD;
        end else begin
            flit_type = is_tail ? TYPE_TAIL : TYPE_BODY;
        end
    end

    // Per-VC credit return / consumption decode. A return and a send on
    // the same VC in one cycle cancel; a lone return on a full counter is
    // an overflow.
    always_comb begin
        ret_vec  = '0;
        take_vec = '0;
        ovf_vec  = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            ret_vec[k]  = credit_valid && (credit_vc == VC_BITS'(k));
            take_vec[k] = send_fire && (cur_vc == VC_BITS'(k));
            ovf_vec[k]  = ret_vec[k] && !take_vec[k] && (credit[k] == CREDIT_FULL);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (hit) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = ST_IDLE;
                    end else if (at_max) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && in_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. in_ready in SEND follows the live credit count so
    // a credit returned while stalled re-opens the input on the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_SEND:  in_ready = (credit[cur_vc] != '0);
            ST_DRAIN: in_ready = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Packet context: destination, allocated VC, round-robin pointer and
    // beat counter within the current packet.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            dest_lat <= '0;
            cur_vc   <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if ((state == ST_IDLE) && in_valid) begin
                dest_lat <= in_dest;
            end
            if ((state == ST_ALLOC) && hit) begin
                cur_vc   <= hit_vc;
                rr_ptr   <= rr_next;
                beat_cnt <= '0;
            end
            if (send_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_VC; k++) begin
                credit[k] <= CREDIT_FULL;
            end
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (ret_vec[k] && !take_vec[k]) begin
                    if (credit[k] != CREDIT_FULL) begin
                        credit[k] <= credit[k] + 1'b1;
                    end
                end else if (take_vec[k] && !ret_vec[k]) begin
                    credit[k] <= credit[k] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered flit output and sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            err_credit_ovf <= 1'b0;
            err_truncated  <= 1'b0;
        end else begin
            out_valid <= send_fire;
            if (send_fire) begin
                out_data <= {dest_lat, flit_type, cur_vc, in_payload};
            end
            err_credit_ovf <= err_credit_ovf | (|ovf_vec);
            err_truncated  <= err_truncated | trunc_fire;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ni_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_injector
//  Description : Self-checking bench for ni_injector. Directed scenarios
//                followed by randomized packets, checked every cycle
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_injector;

    localparam int NUM_VC = 4;
    localparam int BUF    = 4;
    localparam int MAXF   = 8;
    localparam int W      = 32;
    localparam int VCB    = 2;
    localparam int PW     = W - 6 - VCB;

    logic          clk;
    logic          rstn;
    logic          iv;
    logic          in_ready;
    logic [PW-1:0] ipl;
    logic          il;
    logic [3:0]    idst;
    logic          cv;
    logic [VCB-1:0] cvc;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          err_credit_ovf;
    logic          err_truncated;

    ni_injector #(
        .NUM_VC          (NUM_VC),
        .BUF_DEPTH       (BUF),
        .MAX_FLITS       (MAXF),
        .FLIT_DATA_WIDTH (W)
    ) dut (
        .clk            (clk),
        .reset          (rstn),
        .in_valid       (iv),
        .in_ready       (in_ready),
        .in_payload     (ipl),
        .in_last        (il),
        .in_dest        (idst),
        .credit_valid   (cv),
        .credit_vc      (cvc),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .err_credit_ovf (err_credit_ovf),
        .err_truncated  (err_truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int flits_seen = 0;

    // ---------------- reference model state ----------------
    // phase: 0 idle, 1 looking for a VC, 2 sending, 3 discarding
    bit          m_known = 0;
    int          m_ph, m_rr, m_vc, m_beats, m_dst;
    int          m_cr [NUM_VC];
    bit          m_ov, m_eovf, m_etr;
    logic [W-1:0] m_od;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        if (m_ph == 2) return m_cr[m_vc] > 0;
        return m_ph == 3;
    endfunction

    // VC the next allocation would pick, or -1 when none has credit.
    function automatic int next_vc();
        for (int k = 0; k < NUM_VC; k++) begin
            int j;
            j = (m_rr + k) % NUM_VC;
            if (m_cr[j] > 0) return j;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int hit, n, typ;
        bit rdy, acc, snd, trunc, tl, up, dn;
        if (!rstn) begin
            m_known = 1; m_ph = 0; m_rr = 0; m_vc = 0; m_beats = 0; m_dst = 0;
            for (int k = 0; k < NUM_VC; k++) m_cr[k] = BUF;
            m_ov = 0; m_od = '0; m_eovf = 0; m_etr = 0;
            return;
        end
        rdy   = model_ready();
        acc   = iv && rdy;
        snd   = acc && (m_ph == 2);
        trunc = 0;
        hit   = next_vc();
        if (snd) begin
            n     = m_beats + 1;
            trunc = !il && (n == MAXF);
            tl    = il || trunc;
            if (m_beats == 0) typ = tl ? 3 : 0;
            else              typ = tl ? 2 : 1;
            m_od  = {4'(m_dst), 2'(typ), VCB'(m_vc), ipl};
            if (trunc) m_etr = 1;
            m_beats = n;
        end
        for (int k = 0; k < NUM_VC; k++) begin
            up = cv && (int'(cvc) == k);
            dn = snd && (m_vc == k);
            if (up && !dn) begin
                if (m_cr[k] == BUF) m_eovf = 1;
                else                m_cr[k]++;
            end else if (dn && !up) begin
                m_cr[k]--;
            end
        end
        case (m_ph)
            0: if (iv) begin m_dst = int'(idst); m_ph = 1; end
            1: if (hit >= 0) begin m_vc = hit; m_rr = (hit + 1) % NUM_VC; m_beats = 0; m_ph = 2; end
            2: if (acc) begin
                   if (il)         m_ph = 0;
                   else if (trunc) m_ph = 3;
               end
            default: if (acc && il) m_ph = 0;
        endcase
        m_ov = snd;
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic tick();
        #1;
        if (m_known) chk("in_ready", 64'(in_ready), 64'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("err_credit_ovf", 64'(err_credit_ovf), 64'(m_eovf));
        chk("err_truncated", 64'(err_truncated), 64'(m_etr));
        for (int k = 0; k < NUM_VC; k++)
            chk($sformatf("credit%0d", k), 64'(dut.credit[k]), 64'(m_cr[k]));
        if (out_valid) flits_seen++;
    endtask

    task automatic idle(input int n);
        iv = 0; il = 0; cv = 0;
        repeat (n) tick();
    endtask

    // mode 0: no credit returns; 1: random returns and input gaps;
    // 2: one credit to the stalled VC after 3 stall cycles;
    // 3: a credit to the active VC on every sending cycle.
    task automatic run_pkt(input int dst, input int nb, input int budget,
                           input int mode, output int done);
        int beat, cyc, stall;
        bit acc_now;
        beat = 0; cyc = 0; stall = 0;
        idst = 4'(dst);
        while (beat < nb && cyc < budget) begin
            iv  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            il  = (beat == nb - 1);
            ipl = PW'($urandom);
            cv  = 0;
            cvc = '0;
            case (mode)
                1: begin
                    cv  = 1'($urandom_range(0, 1));
                    cvc = VCB'($urandom_range(0, NUM_VC - 1));
                end
                2: begin
                    if (m_ph == 2 && m_cr[m_vc] == 0) stall++;
                    else                              stall = 0;
                    if (stall >= 3) begin
                        cv = 1; cvc = VCB'(m_vc); stall = 0;
                    end
                end
                3: if (m_ph == 2) begin cv = 1; cvc = VCB'(m_vc); end
                default: ;
            endcase
            acc_now = iv && model_ready();
            tick();
            if (acc_now) beat++;
            cyc++;
        end
        iv = 0; il = 0; cv = 0;
        done = beat;
    endtask

    initial begin
        int done, v, nb;
        rstn = 0; iv = 0; il = 0; ipl = '0; idst = '0; cv = 0; cvc = '0;

        // Reset
        tick(); tick();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        rstn = 1;
        idle(1);

        // 3-beat packet to dest 5 on VC0
        flits_seen = 0;
        run_pkt(5, 3, 20, 0, done);
        chk("pkt1_beats", 64'(done), 64'(3));
        idle(2);
        chk("pkt1_flits", 64'(flits_seen), 64'(3));
        chk("pkt1_credit0", 64'(dut.credit[0]), 64'(1));

        // Single-beat packet goes to VC1, head+tail
        run_pkt(2, 1, 20, 0, done);
        idle(1);
        chk("pkt2_type", 64'(out_data[W-5 -: 2]), 64'(3));
        chk("pkt2_vc", 64'(out_data[W-7 -: VCB]), 64'(1));
        chk("pkt2_credit1", 64'(dut.credit[1]), 64'(3));

        // 6-beat packet stalls after 4 flits, resumes per returned credit
        run_pkt(9, 6, 60, 2, done);
        chk("pkt3_beats", 64'(done), 64'(6));
        idle(1);
        chk("pkt3_credit2", 64'(dut.credit[2]), 64'(0));

        // Send with same-cycle credit return on the active VC (VC3)
        run_pkt(12, 3, 20, 3, done);
        chk("pkt4_beats", 64'(done), 64'(3));
        idle(1);
        chk("pkt4_credit3", 64'(dut.credit[3]), 64'(4));

        // Credit to full VC3 -> overflow, count saturates
        cv = 1; cvc = 2'd3; tick(); cv = 0;
        idle(1);
        chk("ovf_flag", 64'(err_credit_ovf), 64'(1));
        chk("ovf_credit3", 64'(dut.credit[3]), 64'(4));

        // Top VC0 back up, then a 10-beat packet truncates at 8
        cvc = 2'd0; cv = 1; repeat (3) tick(); cv = 0;
        flits_seen = 0;
        run_pkt(3, 10, 40, 3, done);
        chk("trunc_beats", 64'(done), 64'(10));
        idle(1);
        chk("trunc_flits", 64'(flits_seen), 64'(8));
        chk("trunc_flag", 64'(err_truncated), 64'(1));

        // Exhaust every VC, then hold in ALLOC
        for (int p = 0; p < 8; p++) begin
            v = next_vc();
            if (v < 0) break;
            nb = m_cr[v];
            run_pkt(6, nb, 40, 0, done);
            chk("drain_beats", 64'(done), 64'(nb));
        end
        idle(1);
        iv = 1; il = 0; idst = 4'd7;
        repeat (6) tick();
        chk("alloc_hold_ready", 64'(in_ready), 64'(0));
        chk("alloc_hold_valid", 64'(out_valid), 64'(0));
        cv = 1; cvc = 2'd1; tick(); cv = 0;
        run_pkt(7, 3, 8, 0, done);
        chk("stall_beats", 64'(done), 64'(1));

        // Reset in the middle of SEND
        rstn = 0; iv = 1; tick(); iv = 0;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_data", 64'(out_data), 64'(0));
        chk("midrst_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < NUM_VC; k++)
            chk("midrst_credit", 64'(dut.credit[k]), 64'(4));
        rstn = 1;
        idle(2);

        // Randomized packets with random credit returns
        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 11);
            run_pkt($urandom_range(0, 15), nb, 300, 1, done);
            chk("rand_beats", 64'(done), 64'(nb));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
